// File: rtl/thoth_top.sv
// Minimal RV32I multicycle core running a fixed internal ROM program.
// Core steps on a divided clock-enable; x1[15:0] is exposed for debug.
module thoth_top #(
    parameter int CLK_DIV   = 100,
    parameter int ROM_DEPTH = 64,
    parameter int ROM_SEL   = 0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [15:0] r1_o
);

    // state    | meaning
    // ST_FETCH | on tick: IR <= ROM[PC], go to EXEC
    // ST_EXEC  | on tick: execute IR, write back rd, update PC, go to FETCH
    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_EXEC  = 1'b1;

    localparam int          DIV_W  = $clog2(CLK_DIV);
    localparam int          ROM_AW = $clog2(ROM_DEPTH);
    localparam logic [31:0] NOP    = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [0:0]       state;
    logic [31:0]      pc;
    logic [31:0]      ir;
    logic [31:0]      regs [32];

    // ROM_SEL=1 selects an ALU/x0 exercise program instead of the counter program.
    function automatic logic [31:0] rom_word(input logic [ROM_AW-1:0] idx);
        logic [31:0] w;
        w = NOP;
        if (ROM_SEL == 0) begin
            case (idx)
                ROM_AW'(0): w = 32'h0000_0093;
                ROM_AW'(1): w = 32'h0010_8093;
                ROM_AW'(2): w = 32'h0010_8093;
                ROM_AW'(3): w = 32'h0010_8093;
                ROM_AW'(4): w = 32'h0000_006F;
                default:    w = NOP;
            endcase
        end else begin
            case (idx)
                ROM_AW'(0): w = 32'h0010_0113;
                ROM_AW'(1): w = 32'h4020_00B3;
                ROM_AW'(2): w = 32'h8000_01B7;
                ROM_AW'(3): w = 32'h4041_D093;
                ROM_AW'(4): w = 32'h0100_D093;
                ROM_AW'(5): w = 32'h0050_0013;
                ROM_AW'(6): w = 32'h0000_00B3;
                ROM_AW'(7): w = 32'h0000_006F;
                default:    w = NOP;
            endcase
        end
        return w;
    endfunction

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] wb_data;
    logic        wr_en;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7b5   = ir[30];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign op_b     = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign shamt    = op_b[4:0];
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        alu_res = 32'd0;
        case (funct3)
            // ir[30] is an immediate bit for ADDI, so SUB exists only in OP
            3'b000: alu_res = ((opcode == OPC_OP) && f7b5) ? (rs1_val - op_b)
                                                           : (rs1_val + op_b);
            3'b001: alu_res = rs1_val << shamt;
            3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
            3'b011: alu_res = {31'd0, rs1_val < op_b};
            3'b100: alu_res = rs1_val ^ op_b;
            3'b101: alu_res = f7b5 ? 32'($signed(rs1_val) >>> shamt)
                                   : (rs1_val >> shamt);
            3'b110: alu_res = rs1_val | op_b;
            3'b111: alu_res = rs1_val & op_b;
            default: alu_res = 32'd0;
        endcase
    end

    always_comb begin
        next_pc = pc_plus4;
        wb_data = alu_res;
        wr_en   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                wr_en   = 1'b1;
                wb_data = imm_u;
            end
            OPC_AUIPC: begin
                wr_en   = 1'b1;
                wb_data = pc + imm_u;
            end
            OPC_JAL: begin
                wr_en   = 1'b1;
                wb_data = pc_plus4;
                next_pc = pc + imm_j;
            end
            OPC_OPIMM, OPC_OP: begin
                wr_en   = 1'b1;
                wb_data = alu_res;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= ST_FETCH;
            pc    <= 32'd0;
            ir    <= NOP;
        end else if (tick) begin
            case (state)
                ST_FETCH: begin
                    ir    <= rom_word(pc[ROM_AW+1:2]);
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    pc    <= next_pc;
                    state <= ST_FETCH;
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (tick && (state == ST_EXEC) && wr_en && (rd != 5'd0)) begin
            regs[rd] <= wb_data;
        end
    end

    assign r1_o = regs[1][15:0];

endmodule

// File: tb/tb_thoth_top.sv
// Directed bench for thoth_top: counter program at CLK_DIV=100 and 2,
// plus the ALU/x0 exercise ROM at CLK_DIV=2.
`timescale 1ns/1ps
module tb_thoth_top;

    logic        clk;
    logic        rst_a;
    logic        rst_b;
    logic [15:0] r1_a;
    logic [15:0] r1_b;
    logic [15:0] r1_c;

    int n_pass  = 0;
    int n_total = 0;

    thoth_top #(.CLK_DIV(100), .ROM_DEPTH(64), .ROM_SEL(0)) dut_a (
        .clk_i(clk), .reset_i(rst_a), .r1_o(r1_a));

    thoth_top #(.CLK_DIV(2), .ROM_DEPTH(64), .ROM_SEL(0)) dut_b (
        .clk_i(clk), .reset_i(rst_b), .r1_o(r1_b));

    thoth_top #(.CLK_DIV(2), .ROM_DEPTH(64), .ROM_SEL(1)) dut_c (
        .clk_i(clk), .reset_i(rst_b), .r1_o(r1_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic at(input time t);
        if (t > $time) #(t - $time);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;

        at(1);
        check("reset_r1_a", 32'(r1_a), 32'h0);
        check("reset_pc_a", dut_a.pc, 32'h0);
        check("reset_tick_a", 32'(dut_a.tick), 32'h0);
        check("reset_r1_c", 32'(r1_c), 32'h0);

        at(2);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // fast divider: tick high in alternating clock cycles
        at(12);  check("fast_tick_1", 32'(dut_b.tick), 32'h1);
        at(22);  check("fast_tick_2", 32'(dut_b.tick), 32'h0);
        at(32);  check("fast_tick_3", 32'(dut_b.tick), 32'h1);

        at(77);  check("alu_sub_r1", 32'(r1_c), 32'h0000_FFFF);
        check("alu_sub_x1", dut_c.regs[1], 32'hFFFF_FFFF);
        at(152); check("fast_r1_before", 32'(r1_b), 32'h2);
        at(157); check("fast_r1_16clk", 32'(r1_b), 32'h3);
        check("alu_srai_x1", dut_c.regs[1], 32'hF800_0000);
        check("alu_srai_r1", 32'(r1_c), 32'h0);
        at(197); check("alu_srli_r1", 32'(r1_c), 32'h0000_F800);
        at(237); check("alu_x0_write", 32'(r1_c), 32'h0000_F800);
        at(277); check("alu_x0_read", 32'(r1_c), 32'h0);

        // slow divider: first tick on the 100th edge (995 ns)
        at(982);  check("first_tick_pre", 32'(dut_a.tick), 32'h0);
        at(992);  check("first_tick", 32'(dut_a.tick), 32'h1);
        at(1002); check("first_exec", 32'(dut_a.state), 32'h1);
        at(2002); check("prog_2us", 32'(r1_a), 32'h0);
        at(4002); check("prog_4us", 32'(r1_a), 32'h1);
        at(6002); check("prog_6us", 32'(r1_a), 32'h2);
        at(7990); check("prog_pre_8th", 32'(r1_a), 32'h2);
        at(8002); check("prog_8us", 32'(r1_a), 32'h3);

        at(18002);
        check("halt_r1", 32'(r1_a), 32'h3);
        check("halt_pc", dut_a.pc, 32'h10);

        rst_a = 1'b1;
        at(18012);
        rst_a = 1'b0;
        // word2 executes between release+4993 and release+5993
        at(23511);
        check("mid_pre_r1", 32'(r1_a), 32'h1);
        check("mid_pre_state", 32'(dut_a.state), 32'h1);
        check("mid_pre_pc", dut_a.pc, 32'h8);
        rst_a = 1'b1;
        at(23513);
        check("mid_reset_r1", 32'(r1_a), 32'h0);
        check("mid_reset_pc", dut_a.pc, 32'h0);
        at(23522);
        rst_a = 1'b0;
        at(29522); check("recount_6us", 32'(r1_a), 32'h2);
        at(31512); check("recount_pre", 32'(r1_a), 32'h2);
        at(31522); check("recount_done", 32'(r1_a), 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
